data_cache: RTL

- Direct-mapped, write-back, write-allocate data cache with one 32-bit word per line.
- Sits directly downstream of the multicycle controller FSM and consumes its strobes: we_cache, set_valid, set_dirty, cache_input_type, is_word, memory_address_type.
- Returns cache_hit and cache_dirty to the controller.
- Holds the tag/valid/dirty/data arrays. Supplies load data to the register-file writeback mux, and the victim address and data to main memory for write-backs.

---
 rtl/data_cache.sv | 112 +++++++++++
 1 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache, one
// 32-bit word per line. Sequencing belongs to the external controller. This
// block holds only the tag/valid/dirty/data arrays, plus the lookup and
// merge logic around them.
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset clears all lines
//   address             - byte address: tag | index | byte lane
//   store_data          - store operand (word, or byte in [7:0])
//   mem_read_data       - word from main memory for line fills
//   cache_input_type    - write source: 0 = fill from memory, 1 = store
//   we_cache            - write the indexed line this cycle
//   set_valid/set_dirty - valid/dirty values written when we_cache=1
//   is_word/is_unsigned - access size and byte-load extension
//   memory_address_type - mem_address source: 0 = address, 1 = victim
//   cache_hit/cache_dirty - combinational lookup status for the controller
//   read_data           - load result (unqualified; controller checks hit)
//   victim_address/victim_data - indexed line's address and word for write-back
//   mem_address         - word-aligned address presented to main memory
module data_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           store_data,
    input  logic [31:0]           mem_read_data,
    input  logic                  cache_input_type,
    input  logic                  we_cache,
    input  logic                  set_valid,
    input  logic                  set_dirty,
    input  logic                  is_word,
    input  logic                  is_unsigned,
    input  logic                  memory_address_type,
    output logic                  cache_hit,
    output logic                  cache_dirty,
    output logic [31:0]           read_data,
    output logic [ADDR_WIDTH-1:0] victim_address,
    output logic [31:0]           victim_data,
    output logic [ADDR_WIDTH-1:0] mem_address
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int LINES    = 2 ** INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] idx;
    logic [1:0]            byte_sel;
    logic [31:0]           cur_word;
    logic [7:0]            cur_byte;
    logic [31:0]           wr_word;

    assign addr_tag = address[ADDR_WIDTH-1:INDEX_BITS+2];
    assign idx      = address[INDEX_BITS+1:2];
    assign byte_sel = address[1:0];
    assign cur_word = data_q[idx];
    assign cur_byte = cur_word[{byte_sel, 3'b000} +: 8];

    // Zero-latency lookup: the controller samples these in the same cycle.
    assign cache_hit   = valid_q[idx] & (tag_q[idx] == addr_tag);
    // Dirty does not compare the tag: it answers "does a miss here need a write-back".
    assign cache_dirty = valid_q[idx] & dirty_q[idx];

    always_comb begin
        read_data = cur_word;
        if (!is_word) begin
            read_data = {{24{cur_byte[7] & ~is_unsigned}}, cur_byte};
        end
    end

    assign victim_address = {tag_q[idx], idx, 2'b00};
    assign victim_data    = cur_word;
    assign mem_address    = memory_address_type ? victim_address
                                                : {address[ADDR_WIDTH-1:2], 2'b00};

    // Write data: fills always replace the whole word; byte stores merge one
    // lane into the current word.
    always_comb begin
        wr_word = cur_word;
        if (!cache_input_type) begin
            wr_word = mem_read_data;
        end else if (is_word) begin
            wr_word = store_data;
        end else begin
            wr_word[{byte_sel, 3'b000} +: 8] = store_data[7:0];
        end
    end

    // Reset takes priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (we_cache) begin
            valid_q[idx] <= set_valid;
            dirty_q[idx] <= set_dirty;
            tag_q[idx]   <= addr_tag;
            data_q[idx]  <= wr_word;
        end
    end

endmodule
